// File: rtl/sd_to_binary_converter.sv
// Digit-serial binary signed-digit (pos - neg) to two's-complement converter.
// Optional invalid-digit checking is enabled by defining SD_DIGIT_CHECK_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for an operand, in_ready high, result held
// CONVERT | resolving DPC digits per clock through the borrow chain
// DONE    | result presented with out_valid, waiting for out_ready
module sd_to_binary_converter #(
    parameter int WIDTH = 16,
    parameter int DPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pos,
    input  logic [WIDTH-1:0] neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             busy,
    output logic             err
);

    localparam int STEPS = WIDTH / DPC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if ((WIDTH % DPC) != 0) begin : g_bad_dpc
            $error("sd_to_binary_converter: DPC must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pos_sr;
    logic [WIDTH-1:0] neg_sr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]   result_q;
    logic [DPC:0]     diff;
    logic [CNT_W-1:0] cnt;
    logic             borrow;
    logic             accept;
    logic             last_step;

    // diff[DPC] is set exactly when p - n - borrow goes negative: the borrow-out.
    always_comb begin
        diff      = {1'b0, pos_sr[DPC-1:0]} - {1'b0, neg_sr[DPC-1:0]} - {{DPC{1'b0}}, borrow};
        acc_nxt   = WIDTH'({diff[DPC-1:0], acc} >> DPC);
        last_step = (cnt == CNT_W'(STEPS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_sr   <= '0;
            neg_sr   <= '0;
            acc      <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
        end else if (accept) begin
            pos_sr <= pos;
            neg_sr <= neg;
            acc    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (state == CONVERT) begin
            pos_sr <= pos_sr >> DPC;
            neg_sr <= neg_sr >> DPC;
            acc    <= acc_nxt;
            borrow <= diff[DPC];
            cnt    <= cnt + CNT_W'(1);
            if (last_step) begin
                result_q <= {diff[DPC], acc_nxt};
            end
        end
    end

    assign result = result_q;

`ifdef SD_DIGIT_CHECK_EN
    logic err_q;

    // A digit with both bits set is legal arithmetically but non-canonical.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= |(pos & neg);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
